// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
//   ROB_ADDR_WIDTH : width of a ROB tag
//   XLEN           : architectural data width
//   cdb_pkt_t      : one Common Data Bus broadcast (valid, tag, data), used by the
//                    ROB and reservation-station CDB ports
//   idx_width()    : index width for an N-entry vector, never less than one bit
package cpu_pkg;

    localparam int unsigned ROB_ADDR_WIDTH = 4;
    localparam int unsigned XLEN           = 32;

    typedef struct packed {
        logic                      valid;
        logic [ROB_ADDR_WIDTH-1:0] tag;
        logic [XLEN-1:0]           data;
    } cdb_pkt_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
//   req       : request vector
//   ptr       : index with highest priority; must be below NUM_REQ
//   grant_oh  : one-hot grant, zero when nothing requests
//   grant_idx : index of the granted request, zero when nothing requests
//   any_grant : a request was granted
module rr_pick
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]            req,
    input  logic [idx_width(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]            grant_oh,
    output logic [idx_width(NUM_REQ)-1:0] grant_idx,
    output logic                          any_grant
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    // One spare bit so ptr + k cannot overflow before the wrap.
    logic [IDX_W:0] pos;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(k);
            // ptr < NUM_REQ and k < NUM_REQ, so a single subtract wraps it.
            if (pos >= (IDX_W + 1)'(NUM_REQ)) begin
                pos = pos - (IDX_W + 1)'(NUM_REQ);
            end
            if (!any_grant && req[pos[IDX_W-1:0]]) begin
                any_grant                = 1'b1;
                grant_idx                = pos[IDX_W-1:0];
                grant_oh[pos[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter. Each functional unit hands its result to a one-entry
// holding buffer; a round-robin scheduler grants one buffer per cycle onto a
// registered CDB broadcast.
//   clock, reset : system clock, synchronous active-high reset
//   req_valid    : per-FU result valid
//   req_tag      : per-FU ROB tag, FU i at [i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH]
//   req_data     : per-FU result, FU i at [i*XLEN +: XLEN]
//   req_ready    : per-FU accept (independent of req_valid)
//   flush        : drop all buffered and in-flight results
//   cdb_valid    : registered broadcast valid
//   cdb_tag      : registered broadcast tag (holds when not valid)
//   cdb_data     : registered broadcast data (holds when not valid)
//   pending      : per-FU holding-buffer occupancy
module cdb_arbiter #(
    parameter int unsigned NUM_FU         = 3,
    parameter int unsigned ROB_ADDR_WIDTH = cpu_pkg::ROB_ADDR_WIDTH,
    parameter int unsigned XLEN           = cpu_pkg::XLEN
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_FU-1:0]                req_valid,
    input  logic [NUM_FU*ROB_ADDR_WIDTH-1:0] req_tag,
    input  logic [NUM_FU*XLEN-1:0]           req_data,
    output logic [NUM_FU-1:0]                req_ready,
    input  logic                             flush,
    output logic                             cdb_valid,
    output logic [ROB_ADDR_WIDTH-1:0]        cdb_tag,
    output logic [XLEN-1:0]                  cdb_data,
    output logic [NUM_FU-1:0]                pending
);

    localparam int unsigned IDX_W = cpu_pkg::idx_width(NUM_FU);

    logic [NUM_FU-1:0]         buf_valid_q, buf_valid_d;
    logic [ROB_ADDR_WIDTH-1:0] buf_tag_q  [NUM_FU];
    logic [ROB_ADDR_WIDTH-1:0] buf_tag_d  [NUM_FU];
    logic [XLEN-1:0]           buf_data_q [NUM_FU];
    logic [XLEN-1:0]           buf_data_d [NUM_FU];
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;

    logic                      cdb_valid_q, cdb_valid_d;
    logic [ROB_ADDR_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]           cdb_data_q, cdb_data_d;

    logic [NUM_FU-1:0]         grant_oh;
    logic [IDX_W-1:0]          grant_idx;
    logic                      any_grant;

    rr_pick #(
        .NUM_REQ (NUM_FU)
    ) u_rr_pick (
        .req       (buf_valid_q),
        .ptr       (rr_ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // A buffer being drained this cycle can be refilled on the same edge, which
    // lets a continuously granted FU stream one result per cycle.
    assign req_ready = (reset || flush) ? '0 : (~buf_valid_q | grant_oh);

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;

        if (flush) begin
            buf_valid_d = '0;
        end else begin
            if (any_grant) begin
                cdb_valid_d            = 1'b1;
                cdb_tag_d              = buf_tag_q[grant_idx];
                cdb_data_d             = buf_data_q[grant_idx];
                buf_valid_d[grant_idx] = 1'b0;
                rr_ptr_d = (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + IDX_W'(1);
            end
            // Loads come after the grant clear so a same-edge refill wins.
            for (int i = 0; i < NUM_FU; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    buf_valid_d[i] = 1'b1;
                    buf_tag_d[i]   = req_tag[i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH];
                    buf_data_d[i]  = req_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid_q <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    // Payload is qualified by buf_valid_q, so it needs no reset.
    always_ff @(posedge clock) begin
        buf_tag_q  <= buf_tag_d;
        buf_data_q <= buf_data_d;
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign pending   = buf_valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a cycle model of buffer occupancy and the
// round-robin pointer, plus per-FU scoreboard queues filled on acceptance and
// drained as results appear on the CDB.
module tb_cdb_arbiter;

    localparam int N  = 3;
    localparam int RW = 4;
    localparam int XW = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N*RW-1:0] req_tag;
    logic [N*XW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            cdb_valid;
    logic [RW-1:0]   cdb_tag;
    logic [XW-1:0]   cdb_data;
    logic [N-1:0]    pending;

    cdb_arbiter #(
        .NUM_FU         (N),
        .ROB_ADDR_WIDTH (RW),
        .XLEN           (XW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .pending   (pending)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state.
    logic [N-1:0]       m_valid;
    int                 m_ptr;
    logic               m_cdb_v;
    logic [RW-1:0]      m_cdb_tag;
    logic [XW-1:0]      m_cdb_data;
    logic [RW+XW-1:0]   exp_q [N][$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int fu, input logic v, input logic [RW-1:0] t,
                         input logic [XW-1:0] d);
        req_valid[fu]          = v;
        req_tag[fu*RW +: RW]   = t;
        req_data[fu*XW +: XW]  = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
    endtask

    // One clock cycle: check combinational outputs before the edge, advance the
    // model on the edge, check the registered CDB just after it.
    task automatic tick();
        int               g;
        logic [N-1:0]     gnt_oh;
        logic [N-1:0]     exp_rdy;
        logic [RW+XW-1:0] ent;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && m_valid[idx]) g = idx;
        end
        gnt_oh = '0;
        if (g >= 0) gnt_oh[g] = 1'b1;
        exp_rdy = (reset || flush) ? '0 : (~m_valid | gnt_oh);

        @(negedge clock);
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("pending", 64'(pending), 64'(m_valid));

        @(posedge clock);
        if (reset) begin
            m_valid    = '0;
            m_ptr      = 0;
            m_cdb_v    = 1'b0;
            m_cdb_tag  = '0;
            m_cdb_data = '0;
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else if (flush) begin
            m_valid = '0;
            m_cdb_v = 1'b0;
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else begin
            if (g >= 0) begin
                if (exp_q[g].size() == 0) begin
                    check("sb_underflow", 64'(1), 64'(0));
                end else begin
                    ent        = exp_q[g].pop_front();
                    m_cdb_tag  = ent[RW+XW-1:XW];
                    m_cdb_data = ent[XW-1:0];
                end
                m_cdb_v    = 1'b1;
                m_valid[g] = 1'b0;
                m_ptr      = (g + 1) % N;
            end else begin
                m_cdb_v = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && exp_rdy[i]) begin
                    m_valid[i] = 1'b1;
                    exp_q[i].push_back({req_tag[i*RW +: RW], req_data[i*XW +: XW]});
                end
            end
        end

        #1;
        check("cdb_valid", 64'(cdb_valid), 64'(m_cdb_v));
        check("cdb_tag", 64'(cdb_tag), 64'(m_cdb_tag));
        check("cdb_data", 64'(cdb_data), 64'(m_cdb_data));
    endtask

    initial begin
        int left;
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
        m_valid    = '0;
        m_ptr      = 0;
        m_cdb_v    = 1'b0;
        m_cdb_tag  = '0;
        m_cdb_data = '0;
        @(posedge clock);
        #1;

        // Reset state.
        tick();
        tick();
        check("reset_cdb_valid", 64'(cdb_valid), 64'(0));
        reset = 1'b0;
        tick();

        // Single request: visible on the CDB one edge after acceptance.
        drive(1, 1'b1, 4'd5, 32'h1234);
        tick();
        check("single_not_early", 64'(cdb_valid), 64'(0));
        clear_reqs();
        tick();
        check("single_valid", 64'(cdb_valid), 64'(1));
        check("single_tag", 64'(cdb_tag), 64'(5));
        check("single_data", 64'(cdb_data), 64'h1234);
        tick();
        check("single_one_cycle", 64'(cdb_valid), 64'(0));

        // Three-way contention from rr_ptr = 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 1'b1, 4'd1, 32'hA1);
        drive(1, 1'b1, 4'd2, 32'hA2);
        drive(2, 1'b1, 4'd3, 32'hA3);
        tick();
        clear_reqs();
        tick();
        check("three_first", 64'(cdb_tag), 64'(1));
        tick();
        check("three_second", 64'(cdb_tag), 64'(2));
        tick();
        check("three_third", 64'(cdb_tag), 64'(3));
        tick();

        // Streaming from FU0.
        for (int t = 0; t < 8; t++) begin
            drive(0, 1'b1, 4'(t), 32'h100 + 32'(t));
            tick();
        end
        clear_reqs();
        tick();
        tick();

        // Fairness: FU0 always valid, FU2 once.
        for (int c = 0; c < 12; c++) begin
            drive(0, 1'b1, 4'(c), $urandom);
            drive(2, c == 3, 4'hF, 32'hF2F2);
            tick();
        end
        clear_reqs();
        repeat (4) tick();

        // Flush with two buffers full and a request presented alongside.
        drive(0, 1'b1, 4'd4, 32'h44);
        drive(2, 1'b1, 4'd6, 32'h66);
        tick();
        clear_reqs();
        flush = 1'b1;
        drive(1, 1'b1, 4'd7, 32'h77);
        tick();
        check("flush_pending", 64'(pending), 64'(0));
        check("flush_cdb_valid", 64'(cdb_valid), 64'(0));
        flush = 1'b0;
        drive(1, 1'b1, 4'd9, 32'hBEEF);
        tick();
        clear_reqs();
        tick();
        check("post_flush_valid", 64'(cdb_valid), 64'(1));
        check("post_flush_tag", 64'(cdb_tag), 64'(9));
        tick();

        // Reset in the middle of traffic.
        drive(0, 1'b1, 4'd10, 32'hC0);
        drive(1, 1'b1, 4'd11, 32'hC1);
        drive(2, 1'b1, 4'd12, 32'hC2);
        tick();
        tick();
        check("midrst_pending", 64'(pending), 64'b111);
        check("midrst_cdb", 64'(cdb_valid), 64'(1));
        reset = 1'b1;
        tick();
        check("rst_pending", 64'(pending), 64'(0));
        check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
        check("rst_cdb_data", 64'(cdb_data), 64'(0));
        reset = 1'b0;
        clear_reqs();
        drive(1, 1'b1, 4'd13, 32'hD1);
        drive(2, 1'b1, 4'd14, 32'hD2);
        tick();
        clear_reqs();
        tick();
        check("rst_first_grant", 64'(cdb_tag), 64'(13));
        tick();
        check("rst_second_grant", 64'(cdb_tag), 64'(14));

        // Random traffic with occasional flush.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                drive(i, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
            end
            flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0;
        clear_reqs();
        repeat (N + 3) tick();

        left = 0;
        for (int i = 0; i < N; i++) left += exp_q[i].size();
        check("sb_drained", 64'(left), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
